// File: rtl/fuzz_seq.sv
// fuzz_seq: time-shares one external fuzzifier between the error sample and
// the delta-error sample. The block issues e and then de, waits out the
// fuzzifier latency and captures six clamped Q1.15 memberships.
module fuzz_seq #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  e_in,
  input  logic [7:0]  de_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  fz_x,
  output logic        fz_sel,
  output logic        fz_vld,
  input  logic [15:0] fz_mu_neg,
  input  logic [15:0] fz_mu_zero,
  input  logic [15:0] fz_mu_pos,
  output logic [15:0] mu_e_neg,
  output logic [15:0] mu_e_zero,
  output logic [15:0] mu_e_pos,
  output logic [15:0] mu_de_neg,
  output logic [15:0] mu_de_zero,
  output logic [15:0] mu_de_pos,
  output logic        sat_err
);

  typedef enum logic [2:0] {IDLE, ISSUE_E, ISSUE_DE, WAIT, DONE} state_t;

  // WAIT lasts LAT cycles; the counter reaches 0 in the cycle before DONE.
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  localparam bit         LAT_ONE  = (LAT == 1);
  localparam logic [15:0] MU_MAX  = 16'h8000;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_de;
  logic        r_busy, r_done, r_fz_sel, r_fz_vld, r_sat;
  logic [7:0]  r_fz_x;
  logic [15:0] r_e_n, r_e_z, r_e_p, r_d_n, r_d_z, r_d_p;

  logic        w_cap_e, w_cap_de, w_over;
  logic [15:0] w_cl_n, w_cl_z, w_cl_p;

  // The e result emerges LAT cycles after ISSUE_E: still inside ISSUE_DE when
  // LAT=1, otherwise one cycle before the de result at the end of WAIT.
  assign w_cap_e  = LAT_ONE ? (r_state == ISSUE_DE) : (r_state == WAIT && r_cnt == 3'd1);
  assign w_cap_de = (r_state == WAIT) && (r_cnt == 3'd0);

  // Saturate memberships to 1.0 and flag anything above it
  assign w_cl_n = (fz_mu_neg  > MU_MAX) ? MU_MAX : fz_mu_neg;
  assign w_cl_z = (fz_mu_zero > MU_MAX) ? MU_MAX : fz_mu_zero;
  assign w_cl_p = (fz_mu_pos  > MU_MAX) ? MU_MAX : fz_mu_pos;
  assign w_over = (fz_mu_neg > MU_MAX) || (fz_mu_zero > MU_MAX) || (fz_mu_pos > MU_MAX);

  // Sequencer, registered outputs and membership capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_de     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fz_x   <= '0;
      r_fz_sel <= 1'b0;
      r_fz_vld <= 1'b0;
      r_sat    <= 1'b0;
      r_e_n    <= '0;
      r_e_z    <= '0;
      r_e_p    <= '0;
      r_d_n    <= '0;
      r_d_z    <= '0;
      r_d_p    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_fz_x   <= '0;
      r_fz_sel <= 1'b0;
      r_fz_vld <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // e goes straight to the operand register; de waits one cycle
            r_de     <= de_in;
            r_fz_x   <= e_in;
            r_fz_vld <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE_E;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE_E: begin
          r_fz_x   <= r_de;
          r_fz_sel <= 1'b1;
          r_fz_vld <= 1'b1;
          r_state  <= ISSUE_DE;
        end
        ISSUE_DE: begin
          r_cnt   <= CNT_INIT;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_cap_e) begin
        r_e_n <= w_cl_n;
        r_e_z <= w_cl_z;
        r_e_p <= w_cl_p;
      end
      if (w_cap_de) begin
        r_d_n <= w_cl_n;
        r_d_z <= w_cl_z;
        r_d_p <= w_cl_p;
      end
      if ((w_cap_e || w_cap_de) && w_over) r_sat <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign fz_x       = r_fz_x;
  assign fz_sel     = r_fz_sel;
  assign fz_vld     = r_fz_vld;
  assign mu_e_neg   = r_e_n;
  assign mu_e_zero  = r_e_z;
  assign mu_e_pos   = r_e_p;
  assign mu_de_neg  = r_d_n;
  assign mu_de_zero = r_d_z;
  assign mu_de_pos  = r_d_p;
  assign sat_err    = r_sat;

endmodule

// File: doc/fuzz_seq.md
FUZZ_SEQ -- requirements
Module: fuzz_seq

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the fuzzifier latency in cycles from fz_x to valid mu; legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to fuzzify one (e, de) sample pair.
REQ-005 e_in  input  8  signed Q7.0 error sample.
REQ-006 de_in  input  8  signed Q7.0 delta-error sample.
REQ-007 busy  output  1  sequence in progress; start is ignored while high.
REQ-008 done  output  1  one-cycle pulse; all six mu outputs updated.
REQ-009 fz_x  output  8  signed Q7.0 operand driven to the shared fuzzifier.
REQ-010 fz_sel  output  1  parameter-set select for the external MF bank mux: 0 = e set, 1 = de set.
REQ-011 fz_vld  output  1  high in cycles where fz_x carries a live operand.
REQ-012 fz_mu_neg, fz_mu_zero, fz_mu_pos  input  16 each  Q1.15 fuzzifier results.
REQ-013 mu_e_neg, mu_e_zero, mu_e_pos  output  16 each  Q1.15 memberships of e.
REQ-014 mu_de_neg, mu_de_zero, mu_de_pos  output  16 each  Q1.15 memberships of de.
REQ-015 sat_err  output  1  sticky flag: a captured mu exceeded 16'h8000.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE_E, ISSUE_DE, WAIT, DONE.
REQ-017 Cycle 0 is the cycle in which start=1 is sampled in IDLE or DONE; e_in and de_in SHALL be latched at the end of cycle 0.
REQ-018 Cycle 1 (ISSUE_E): fz_x = latched e, fz_sel=0, fz_vld=1.
REQ-019 Cycle 2 (ISSUE_DE): fz_x = latched de, fz_sel=1, fz_vld=1.
REQ-020 WAIT SHALL run a down-counter so that fuzzifier outputs are captured into the e registers at the end of cycle 1+LAT and into the de registers at the end of cycle 2+LAT (LAT=1: e capture coincides with ISSUE_DE).
REQ-021 Cycle 3+LAT (DONE): done=1 and busy=0; the six mu outputs SHALL hold the new values from this cycle until the next capture.
REQ-022 busy SHALL be 1 exactly in cycles 1 through 2+LAT.
REQ-023 Outside issue cycles: fz_vld=0, fz_x=0, fz_sel=0.
REQ-024 Each captured mu value > 16'h8000 SHALL be clamped to 16'h8000, and sat_err SHALL be set; sat_err clears only on rst.
REQ-025 start while busy=1 SHALL be ignored, with no queueing.
REQ-026 start during DONE SHALL be accepted as a new cycle 0, giving a throughput of one sample pair per LAT+3 cycles.
REQ-027 The mu output registers SHALL update only on their own capture edge; the e registers are updated before the de registers within a sequence.
REQ-028 The block SHALL contain no combinational path from fz_mu_* to any output.

Reset
REQ-029 When rst=1 at a rising edge, the FSM SHALL enter IDLE, clear the counter and latched inputs, and drive busy=0, done=0, fz_vld=0, fz_x=0, fz_sel=0, sat_err=0 and all six mu outputs = 0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted mid-sequence SHALL abort the sequence with no done pulse and no further capture.

Verification
REQ-032 LAT=2, fuzzifier stub with 2-cycle latency returning neg=|x|<<8, zero=16'h4000+x, pos=16'h0100*sel; start with e=-50, de=20 -> fz_x=-50 in cycle 1, 20 in cycle 2; done in cycle 5; mu_e_neg=16'h3200, mu_e_zero=16'h3FCE, mu_e_pos=0, mu_de_neg=16'h1400, mu_de_zero=16'h4014, mu_de_pos=16'h0100.
REQ-033 Start held high continuously for 20 cycles at LAT=2 -> done pulses in cycles 5, 10, 15, 20; busy low only in done cycles and in cycle 0.
REQ-034 Stub returns fz_mu_pos=16'hFFFF on the de capture -> mu_de_pos=16'h8000 and sat_err=1; sat_err stays 1 through a later clean sequence until rst.
REQ-035 rst pulsed in cycle 3 of a sequence -> no done pulse; all outputs 0 in cycle 4; a new start in cycle 5 completes normally with done in cycle 10.
REQ-036 LAT=1 and LAT=8 builds with the same stimulus as REQ-032 -> done in cycle 4 and cycle 11 respectively, with identical mu values.
